// File: rtl/barrier_controller_pkg.sv
// Shared definitions for the barrier controller: state encoding and default sizes.
package barrier_controller_pkg;

  localparam int NUM_PORTS_DEF = 5;
  localparam int TIMEOUT_W_DEF = 16;
  localparam int CNT_W_DEF     = 16;

  // Binary encoding; the unused code 2'b11 is treated as illegal and recovers to idle.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_RELEASE = 2'b10
  } barrier_state_e;

endpackage

// File: rtl/barrier_controller_if.sv
// Participant/engine-facing signal bundle for the barrier controller.
//
// Handshake: each participant raises its req_bus bit and holds it (level) until
// proceed is observed high, then drops it. proceed stays high until every masked
// request has dropped, completing a 4-phase req/proceed exchange.
interface barrier_controller_if
  import barrier_controller_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
);
  logic [NUM_PORTS-1:0] req_bus;
  logic [NUM_PORTS-1:0] enable_mask;
  logic [TIMEOUT_W-1:0] timeout_cycles;
  logic                 proceed;
  logic                 busy;
  logic                 timeout;
  logic [NUM_PORTS-1:0] missing_mask;
  logic [CNT_W-1:0]     barrier_count;
  barrier_state_e       state;

  // Participant side / stimulus engine.
  modport master (
    output req_bus, enable_mask, timeout_cycles,
    input  proceed, busy, timeout, missing_mask, barrier_count, state
  );

  // Controller side.
  modport slave (
    input  req_bus, enable_mask, timeout_cycles,
    output proceed, busy, timeout, missing_mask, barrier_count, state
  );
endinterface

// File: rtl/barrier_controller_timeout_timer.sv
// Saturating cycle timer with an expiry compare; a zero limit disables expiry.
module barrier_timeout_timer #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic                 expired
);
  logic [TIMEOUT_W-1:0] timer;

  // Count while enabled, hold at all-ones, restart from zero on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable && (timer != '1)) begin
      timer <= timer + 1'b1;
    end
  end

  // The limit is compared live, so a change to timeout_cycles takes effect at once.
  assign expired = (timeout_cycles != '0) && (timer == (timeout_cycles - 1'b1));
endmodule

// File: rtl/barrier_controller.sv
// Barrier controller: collects masked participant requests, then releases all of
// them together with a common proceed, force-releasing on an optional timeout.
module barrier_controller
  import barrier_controller_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic                 axis_aclk,
  input logic                 reset,
  barrier_controller_if.slave bus
);
  barrier_state_e       state;
  logic [NUM_PORTS-1:0] mask_q;
  logic [NUM_PORTS-1:0] arrived;
  logic                 all_arrived;
  logic                 none_held;
  logic                 expired;
  logic                 timer_clear;
  logic                 timer_enable;

  assign arrived      = bus.req_bus & mask_q;
  assign all_arrived  = (arrived == mask_q);
  assign none_held    = (arrived == '0);
  assign timer_clear  = (state == ST_IDLE);
  assign timer_enable = (state == ST_COLLECT);

  barrier_timeout_timer #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timer (
    .clk            (axis_aclk),
    .rst            (reset),
    .clear          (timer_clear),
    .enable         (timer_enable),
    .timeout_cycles (bus.timeout_cycles),
    .expired        (expired)
  );

  // Barrier sequencing FSM; every output is a register updated alongside the state.
  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      mask_q            <= '0;
      bus.proceed       <= 1'b0;
      bus.busy          <= 1'b0;
      bus.timeout       <= 1'b0;
      bus.missing_mask  <= '0;
      bus.barrier_count <= '0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          // An empty enable mask can never start a barrier.
          if ((bus.req_bus & bus.enable_mask) != '0) begin
            mask_q   <= bus.enable_mask;
            bus.busy <= 1'b1;
            state    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          // Full arrival takes priority over a timeout expiring on the same edge.
          if (all_arrived) begin
            bus.proceed       <= 1'b1;
            bus.barrier_count <= bus.barrier_count + 1'b1;
            state             <= ST_RELEASE;
          end else if (expired) begin
            bus.proceed      <= 1'b1;
            bus.timeout      <= 1'b1;
            bus.missing_mask <= mask_q & ~bus.req_bus;
            state            <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // Only masked participants hold the release open.
          if (none_held) begin
            bus.proceed <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          bus.proceed <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.state = state;
endmodule
